instruction_memory_loader: RTL and testbench
============================================

Name: instruction_memory_loader

Overview:
Sequencer that fills the byte-wide instruction memory from the debug unit's serial byte stream before a program run. It accepts bytes one at a time and issues one memory write per byte at consecutive addresses. It assembles each 4-byte group into a big-endian word, first byte at [31:24], matching the memory's read ordering. Loading ends on the HALT word or when memory is full.

Parameters:
MEMORY_WIDTH, 8, data width of one memory entry (byte)
MEMORY_DEPTH, 256, number of memory entries; must be a multiple of 4
NB_ADDR, 32, write address width
NB_INSTRUCTION, 32, instruction word width (4 x MEMORY_WIDTH)
HALT_INSTRUCTION, 32'hFFFFFFFF, word value that terminates loading

Ports:
i_clock  input  1  system clock, all state on rising edge
i_reset  input  1  asynchronous active-high reset
i_start  input  1  debug unit request to begin a load; level, sampled only in IDLE/DONE/ERROR
i_rx_valid  input  1  one-cycle strobe: i_rx_data holds a new byte
i_rx_data  input  MEMORY_WIDTH  received byte
o_mem_enable  output  1  drives memory i_enable; high in every state except IDLE
o_mem_write_enable  output  1  one-cycle write strobe to memory
o_mem_write_data  output  MEMORY_WIDTH  byte to write
o_mem_write_addr  output  NB_ADDR  byte address to write
o_loading  output  1  high in RECEIVE/WRITE/CHECK
o_done  output  1  high in DONE (HALT word stored)
o_error  output  1  high in ERROR (memory full, no HALT)
o_instr_count  output  NB_ADDR  complete words written, HALT word included

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; address, word shift register and counters cleared. Memory contents are untouched.
- All outputs are registered.
- IDLE: if i_start=1, go to RECEIVE; clear address, shift register and o_instr_count.
- RECEIVE: if i_rx_valid=1, latch i_rx_data and go to WRITE.
- WRITE (exactly 1 cycle): o_mem_write_enable=1, o_mem_write_data = latched byte, o_mem_write_addr = current address.
  - Shift register updates to {word[23:0], byte}; address increments.
  - If the written address[1:0]==3, go to CHECK; otherwise go to RECEIVE.
- CHECK (1 cycle): o_instr_count increments.
  - Assembled word == HALT_INSTRUCTION: go to DONE (HALT takes priority over full).
  - Else address == MEMORY_DEPTH: go to ERROR.
  - Else go to RECEIVE.
- Latency: byte strobed in cycle N (RECEIVE) produces the write strobe in cycle N+1. o_done/o_error assert 2 cycles after the strobe of the 4th byte.
- Bytes strobed in WRITE, CHECK, DONE, ERROR or IDLE are dropped. The UART byte period is far longer than 2 cycles, so no buffering is provided.
- i_start while loading is ignored.
- DONE/ERROR: hold state, with o_mem_write_enable=0, until i_start=1, which restarts as from IDLE. Restart clears o_done/o_error on the next edge.
- HALT is matched only on 4-byte boundaries. A partial word at full memory cannot occur because MEMORY_DEPTH is a multiple of 4.
- Address and o_instr_count never exceed MEMORY_DEPTH and MEMORY_DEPTH/4; no wrap-around. No write is ever issued at address >= MEMORY_DEPTH.
- Reset mid-load aborts with no further writes. Memory keeps the partial program; the next load overwrites it from address 0.

Test Plan:
- Reset: assert i_reset mid-cycle -> all outputs 0 immediately, state IDLE; i_rx_valid pulses cause no writes.
- Normal load: i_start, then bytes 20 01 00 05 FF FF FF FF with 10-cycle gaps -> 8 write strobes at addr 0..7 with matching data; o_done=1, o_instr_count=2, o_loading=0.
- Full memory (MEMORY_DEPTH=16): 16 bytes of 0x00 -> 16 writes at addr 0..15; o_error=1, o_instr_count=4; a 17th byte causes no write.
- Non-halt near miss: FF FF FF 00 then FF FF FF FF -> no DONE after the first word; DONE after the second word, o_instr_count=2.
- Dropped byte: strobe a second byte in the cycle after an accepted byte (WRITE state) -> exactly one write; next accepted byte goes to address+1.
- Reset mid-load after 3 bytes, then reload AA BB CC DD FF FF FF FF -> writes restart at addr 0; o_done=1, o_instr_count=2.

Source files
------------

// File: rtl/instruction_memory_loader_if.sv
// Debug-unit byte stream in, byte-wide instruction memory write port and load status out.
interface instruction_memory_loader_if #(
    parameter int unsigned MEMORY_WIDTH = 8,
    parameter int unsigned NB_ADDR      = 32
);
    logic                    i_start;
    logic                    i_rx_valid;
    logic [MEMORY_WIDTH-1:0] i_rx_data;
    logic                    o_mem_enable;
    logic                    o_mem_write_enable;
    logic [MEMORY_WIDTH-1:0] o_mem_write_data;
    logic [NB_ADDR-1:0]      o_mem_write_addr;
    logic                    o_loading;
    logic                    o_done;
    logic                    o_error;
    logic [NB_ADDR-1:0]      o_instr_count;

    // Loader side.
    modport master (
        input  i_start, i_rx_valid, i_rx_data,
        output o_mem_enable, o_mem_write_enable, o_mem_write_data, o_mem_write_addr,
        output o_loading, o_done, o_error, o_instr_count
    );

    // Debug unit / memory side.
    modport slave (
        output i_start, i_rx_valid, i_rx_data,
        input  o_mem_enable, o_mem_write_enable, o_mem_write_data, o_mem_write_addr,
        input  o_loading, o_done, o_error, o_instr_count
    );
endinterface

// File: rtl/instruction_memory_loader.sv
// Writes the debug unit's byte stream into instruction memory at consecutive addresses,
// stopping on a big-endian HALT word or when memory is full.
module instruction_memory_loader #(
    parameter int unsigned MEMORY_WIDTH   = 8,
    parameter int unsigned MEMORY_DEPTH   = 256,
    parameter int unsigned NB_ADDR        = 32,
    parameter int unsigned NB_INSTRUCTION = 4 * MEMORY_WIDTH,
    parameter logic [NB_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    instruction_memory_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RECEIVE,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                    state;
    logic [NB_ADDR-1:0]        addr;
    logic [NB_INSTRUCTION-1:0] word;
    logic [MEMORY_WIDTH-1:0]   byte_q;
    logic [NB_ADDR-1:0]        write_addr;
    logic                      write_enable;
    logic                      mem_enable;
    logic                      loading;
    logic                      done;
    logic                      error;
    logic [NB_ADDR-1:0]        instr_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            addr         <= '0;
            word         <= '0;
            byte_q       <= '0;
            write_addr   <= '0;
            write_enable <= 1'b0;
            mem_enable   <= 1'b0;
            loading      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            instr_count  <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.i_start) begin
                        state       <= RECEIVE;
                        addr        <= '0;
                        word        <= '0;
                        instr_count <= '0;
                        mem_enable  <= 1'b1;
                        loading     <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                    end
                end
                // Outputs are registered, so the write strobe is launched on the accepting edge.
                RECEIVE: begin
                    if (bus.i_rx_valid) begin
                        state        <= WRITE;
                        byte_q       <= bus.i_rx_data;
                        write_addr   <= addr;
                        write_enable <= 1'b1;
                    end
                end
                WRITE: begin
                    word <= {word[NB_INSTRUCTION-MEMORY_WIDTH-1:0], byte_q};
                    addr <= addr + NB_ADDR'(1);
                    if (addr[1:0] == 2'd3) begin
                        state <= CHECK;
                    end else begin
                        state <= RECEIVE;
                    end
                end
                // HALT wins over full memory when both land on the same word.
                CHECK: begin
                    instr_count <= instr_count + NB_ADDR'(1);
                    if (word == HALT_INSTRUCTION) begin
                        state   <= DONE;
                        loading <= 1'b0;
                        done    <= 1'b1;
                    end else if (addr == NB_ADDR'(MEMORY_DEPTH)) begin
                        state   <= ERROR;
                        loading <= 1'b0;
                        error   <= 1'b1;
                    end else begin
                        state <= RECEIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_mem_enable       = mem_enable;
    assign bus.o_mem_write_enable = write_enable;
    assign bus.o_mem_write_data   = byte_q;
    assign bus.o_mem_write_addr   = write_addr;
    assign bus.o_loading          = loading;
    assign bus.o_done             = done;
    assign bus.o_error            = error;
    assign bus.o_instr_count      = instr_count;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed and random loads checked against a byte-stream model of the loader.
module tb_instruction_memory_loader;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NA    = 32;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    always #5 i_clock = ~i_clock;

    instruction_memory_loader_if #(.MEMORY_WIDTH(W), .NB_ADDR(NA)) bus ();

    instruction_memory_loader #(
        .MEMORY_WIDTH  (W),
        .MEMORY_DEPTH  (DEPTH),
        .NB_ADDR       (NA),
        .NB_INSTRUCTION(32),
        .HALT_INSTRUCTION(32'hFFFF_FFFF)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .bus    (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: what a loader does with each accepted byte.
    int          m_state  = M_IDLE;
    int          m_addr   = 0;
    int          m_count  = 0;
    logic [31:0] m_word   = '0;
    int          m_writes = 0;

    int wr_seen = 0;
    always @(posedge i_clock) begin
        if (bus.o_mem_write_enable === 1'b1) wr_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".mem_enable"}, 32'(bus.o_mem_enable), 32'(m_state != M_IDLE));
        chk({tag, ".loading"}, 32'(bus.o_loading), 32'(m_state == M_LOAD));
        chk({tag, ".done"}, 32'(bus.o_done), 32'(m_state == M_DONE));
        chk({tag, ".error"}, 32'(bus.o_error), 32'(m_state == M_ERR));
        chk({tag, ".count"}, bus.o_instr_count, 32'(m_count));
        chk({tag, ".writes"}, 32'(wr_seen), 32'(m_writes));
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_addr  = 0;
        m_count = 0;
        m_word  = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_writes++;
        m_addr++;
        m_word = {m_word[23:0], b};
        if (m_addr % 4 == 0) begin
            m_count++;
            if (m_word == 32'hFFFF_FFFF) m_state = M_DONE;
            else if (m_addr == DEPTH) m_state = M_ERR;
        end
    endtask

    task automatic do_start(input string tag);
        @(negedge i_clock);
        bus.i_start = 1'b1;
        @(posedge i_clock);
        #1 bus.i_start = 1'b0;
        if (m_state != M_LOAD) begin
            model_reset();
            m_state = M_LOAD;
        end
        check_status(tag);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input int gap);
        bit accept;
        accept = (m_state == M_LOAD);
        @(negedge i_clock);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        @(posedge i_clock);
        #1 bus.i_rx_valid = 1'b0;
        chk({tag, ".we"}, 32'(bus.o_mem_write_enable), 32'(accept));
        if (accept) begin
            chk({tag, ".addr"}, bus.o_mem_write_addr, 32'(m_addr));
            chk({tag, ".data"}, 32'(bus.o_mem_write_data), 32'(b));
            model_byte(b);
        end
        @(posedge i_clock);
        @(posedge i_clock);
        #1 check_status(tag);
        repeat (gap) @(posedge i_clock);
    endtask

    task automatic send_word(input string tag, input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(tag, w[31-8*k -: 8], gap);
        end
    endtask

    task automatic reset_mid_cycle(input string tag);
        @(posedge i_clock);
        #2 i_reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".we"}, 32'(bus.o_mem_write_enable), 32'd0);
        chk({tag, ".waddr"}, bus.o_mem_write_addr, 32'd0);
        chk({tag, ".wdata"}, 32'(bus.o_mem_write_data), 32'd0);
        check_status(tag);
        @(negedge i_clock) bus.i_rx_valid = 1'b1;
        @(negedge i_clock) bus.i_rx_valid = 1'b0;
        @(negedge i_clock) i_reset = 1'b0;
        @(posedge i_clock);
        #1 check_status({tag, ".after"});
    endtask

    initial begin
        logic [31:0] w;
        bus.i_start    = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;

        // Reset state and idle bytes ignored.
        #2 i_reset = 1'b1;
        #1;
        chk("rst.we", 32'(bus.o_mem_write_enable), 32'd0);
        check_status("rst");
        @(negedge i_clock) i_reset = 1'b0;
        send_byte("idle_drop", 8'h5A, 2);

        // Normal load ending on HALT.
        do_start("norm.start");
        send_word("norm", 32'h2001_0005, 10);
        send_word("norm", 32'hFFFF_FFFF, 10);
        send_byte("norm.after", 8'h11, 2);

        // Fill memory without HALT, then a 17th byte.
        do_start("full.start");
        for (int i = 0; i < 16; i++) send_byte("full", 8'h00, 3);
        send_byte("full.extra", 8'h00, 3);

        // Near-miss HALT, with a start pulse mid-load that must be ignored.
        do_start("near.start");
        send_word("near", 32'hFFFF_FF00, 3);
        do_start("near.ignored_start");
        send_word("near", 32'hFFFF_FFFF, 3);

        // Byte strobed during WRITE is dropped.
        do_start("drop.start");
        @(negedge i_clock);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'h12;
        @(posedge i_clock);
        #1 bus.i_rx_data = 8'h34;
        chk("drop.we", 32'(bus.o_mem_write_enable), 32'd1);
        model_byte(8'h12);
        @(posedge i_clock);
        #1 bus.i_rx_valid = 1'b0;
        chk("drop.we2", 32'(bus.o_mem_write_enable), 32'd0);
        repeat (3) @(posedge i_clock);
        #1 check_status("drop");
        send_byte("drop.next", 8'h56, 3);

        // Reset after 3 bytes, then reload from address 0.
        do_start("mid.start");
        send_byte("mid", 8'h01, 3);
        send_byte("mid", 8'h02, 3);
        send_byte("mid", 8'h03, 3);
        reset_mid_cycle("mid.rst");
        do_start("mid.reload");
        send_word("mid.reload", 32'hAABB_CCDD, 3);
        send_word("mid.reload", 32'hFFFF_FFFF, 3);

        // Random programs ending in HALT.
        for (int t = 0; t < 3; t++) begin
            do_start("rnd.start");
            for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
                w = $urandom;
                if (w == 32'hFFFF_FFFF) w = 32'h0;
                send_word("rnd", w, int'($urandom_range(0, 4)));
            end
            send_word("rnd.halt", 32'hFFFF_FFFF, int'($urandom_range(0, 4)));
        end

        // Random program that overflows memory.
        do_start("rndfull.start");
        for (int n = 0; n < 4; n++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
            send_word("rndfull", w, int'($urandom_range(0, 3)));
        end
        send_byte("rndfull.extra", 8'(($urandom)), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule
